window_gen: RTL and testbench

WINDOW_GEN -- requirements
Module: window_gen

---
 rtl/conv_pkg.sv | 28 ++
 rtl/line_buf.sv | 29 ++
 rtl/window_gen.sv | 231 +++++++++++++++++++++++
 tb/tb_window_gen.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the conv pipeline: channel width, default image
// geometry, window shape and the window generator state encoding.
package conv_pkg;

  localparam int BIT_WIDTH = 8;
  localparam int IMG_W_DEF = 256;
  localparam int IMG_H_DEF = 256;

  // A window is 4x4 pixels; each channel of a window is packed into one bus.
  localparam int WIN_DIM  = 4;
  localparam int WIN_BITS = WIN_DIM * WIN_DIM * BIT_WIDTH;

  // One stored pixel is the three channels side by side.
  localparam int PIX_W = 3 * BIT_WIDTH;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [BIT_WIDTH-1:0] r;
    logic [BIT_WIDTH-1:0] g;
    logic [BIT_WIDTH-1:0] b;
  } pixel_t;

endpackage

// File: rtl/line_buf.sv
// One image-row store: DEPTH entries of WIDTH bits, single column address
// shared by the read and the write port. The read is combinational from the
// current array contents, so a read and a write to the same column in one
// cycle returns the old value (read-before-write). Storage has no reset;
// stale contents are overwritten before they can reach a window.
module line_buf #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 24,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  // Write the incoming value at the addressed column on an enabled cycle.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/window_gen.sv
// 4x4 sliding-window generator for raster-order RGB pixels.
// Three line buffers hold the previous rows; a 4x4 shift window collects one
// new column per accepted pixel and a window is emitted whenever the newest
// pixel is the bottom-right corner of a window on the stride grid.
// Optional build macro: WINDOW_GEN_STRIDE1_EN (defined -> stride 1 windows,
// undefined -> stride 2 windows).
module window_gen
  import conv_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIT_WIDTH-1:0] pix_r,
  input  logic [BIT_WIDTH-1:0] pix_g,
  input  logic [BIT_WIDTH-1:0] pix_b,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  output logic [WIN_BITS-1:0]  win_r,
  output logic [WIN_BITS-1:0]  win_g,
  output logic [WIN_BITS-1:0]  win_b,
  output logic                 win_valid,
  input  logic                 win_ready,
  output logic                 frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_FILLED = RW'(2);
  localparam logic [CW-1:0] COL_WIN0  = CW'(WIN_DIM - 1);
  localparam logic [RW-1:0] ROW_WIN0  = RW'(WIN_DIM - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   col_cnt_q, col_cnt_d;
  logic [RW-1:0]   row_cnt_q, row_cnt_d;
  pixel_t          win_pix_q [WIN_DIM][WIN_DIM];
  pixel_t          win_pix_d [WIN_DIM][WIN_DIM];
  pixel_t          win_shift [WIN_DIM][WIN_DIM];
  logic [WIN_BITS-1:0] win_r_q, win_r_d;
  logic [WIN_BITS-1:0] win_g_q, win_g_d;
  logic [WIN_BITS-1:0] win_b_q, win_b_d;
  logic [WIN_BITS-1:0] pack_r, pack_g, pack_b;
  logic            win_valid_q, win_valid_d;
  logic            frame_done_q, frame_done_d;

  logic            pix_accept;
  logic            win_accept;
  logic            emit;
  logic            last_pixel;
  pixel_t          new_pix;
  logic [PIX_W-1:0] lb_rdata [3];
  logic [PIX_W-1:0] lb_wdata [3];
  pixel_t          col_new [WIN_DIM];

  // A new pixel can enter only when the output slot is free or being freed
  // this cycle, and never while the last window of a frame is still pending.
  assign pix_ready  = (state_q != ST_DRAIN) && (!win_valid_q || win_ready);
  assign pix_accept = pix_valid && pix_ready;
  assign win_accept = win_valid_q && win_ready;
  assign last_pixel = (row_cnt_q == ROW_LAST) && (col_cnt_q == COL_LAST);

  assign new_pix = '{r: pix_r, g: pix_g, b: pix_b};

`ifdef WINDOW_GEN_STRIDE1_EN
  assign emit = (row_cnt_q >= ROW_WIN0) && (col_cnt_q >= COL_WIN0);
`else
  // Row and column are odd exactly when (row-3) and (col-3) are even.
  assign emit = (row_cnt_q >= ROW_WIN0) && (col_cnt_q >= COL_WIN0) &&
                row_cnt_q[0] && col_cnt_q[0];
`endif

  // Rows cascade down the buffers: buffer 0 holds row-1, buffer 1 row-2 and
  // buffer 2 row-3 at the current column.
  assign lb_wdata[0] = new_pix;
  assign lb_wdata[1] = lb_rdata[0];
  assign lb_wdata[2] = lb_rdata[1];

  for (genvar gi = 0; gi < 3; gi++) begin : g_lb
    line_buf #(
      .DEPTH (IMG_W),
      .WIDTH (PIX_W)
    ) u_line_buf (
      .clk_i   (clk),
      .we_i    (pix_accept),
      .addr_i  (col_cnt_q),
      .wdata_i (lb_wdata[gi]),
      .rdata_o (lb_rdata[gi])
    );
  end

  // The column entering the window, top row first.
  assign col_new[0] = lb_rdata[2];
  assign col_new[1] = lb_rdata[1];
  assign col_new[2] = lb_rdata[0];
  assign col_new[3] = new_pix;

  // Shift every window row left by one column and append the new column,
  // then pack the shifted window so it can be loaded as the output directly.
  always_comb begin
    pack_r = '0;
    pack_g = '0;
    pack_b = '0;
    for (int i = 0; i < WIN_DIM; i++) begin
      for (int j = 0; j < WIN_DIM; j++) begin
        if (j == WIN_DIM - 1) begin
          win_shift[i][j] = col_new[i];
        end else begin
          win_shift[i][j] = win_pix_q[i][j+1];
        end
        pack_r[(i*WIN_DIM+j)*BIT_WIDTH +: BIT_WIDTH] = win_shift[i][j].r;
        pack_g[(i*WIN_DIM+j)*BIT_WIDTH +: BIT_WIDTH] = win_shift[i][j].g;
        pack_b[(i*WIN_DIM+j)*BIT_WIDTH +: BIT_WIDTH] = win_shift[i][j].b;
      end
    end
  end

  // The window only moves when a pixel is actually consumed.
  always_comb begin
    win_pix_d = win_pix_q;
    if (pix_accept) begin
      win_pix_d = win_shift;
    end
  end

  // Raster position of the next pixel to be accepted.
  always_comb begin
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    if (pix_accept) begin
      if (col_cnt_q == COL_LAST) begin
        col_cnt_d = '0;
        row_cnt_d = (row_cnt_q == ROW_LAST) ? '0 : row_cnt_q + 1'b1;
      end else begin
        col_cnt_d = col_cnt_q + 1'b1;
      end
    end
  end

  // Output slot: a handshake frees it, a triggering pixel fills it. Both in
  // the same cycle means the new window replaces the one just taken.
  always_comb begin
    win_valid_d = win_valid_q;
    win_r_d     = win_r_q;
    win_g_d     = win_g_q;
    win_b_d     = win_b_q;
    if (win_accept) begin
      win_valid_d = 1'b0;
    end
    if (pix_accept && emit) begin
      win_valid_d = 1'b1;
      win_r_d     = pack_r;
      win_g_d     = pack_g;
      win_b_d     = pack_b;
    end
  end

  // Frame phases: filling the first three rows, running, and draining the
  // final window before the next frame may start.
  always_comb begin
    state_d      = state_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (pix_accept && (row_cnt_q == ROW_FILLED) && (col_cnt_q == COL_LAST)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (pix_accept && last_pixel) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (win_accept) begin
          state_d      = ST_FILL;
          frame_done_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // Control state, counters and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_FILL;
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_r_q      <= '0;
      win_g_q      <= '0;
      win_b_q      <= '0;
    end else begin
      state_q      <= state_d;
      col_cnt_q    <= col_cnt_d;
      row_cnt_q    <= row_cnt_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      win_r_q      <= win_r_d;
      win_g_q      <= win_g_d;
      win_b_q      <= win_b_d;
    end
  end

  // Shift window storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WIN_DIM; i++) begin
        for (int j = 0; j < WIN_DIM; j++) begin
          win_pix_q[i][j] <= '0;
        end
      end
    end else begin
      win_pix_q <= win_pix_d;
    end
  end

  assign win_r      = win_r_q;
  assign win_g      = win_g_q;
  assign win_b      = win_b_q;
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_gen.sv
// Self-checking bench for window_gen on an 8x8 ramp image.
// A scoreboard queue receives the expected window whenever a triggering pixel
// is accepted; a negedge monitor compares each presented window against the
// queue head, checks its latency, the ready logic and the frame_done pulse.
module tb_window_gen;

  localparam int W = 8;
  localparam int H = 8;
`ifdef WINDOW_GEN_STRIDE1_EN
  localparam int EXPW = (W - 3) * (H - 3);
`else
  localparam int EXPW = ((W - 4) / 2 + 1) * ((H - 4) / 2 + 1);
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   pix_r, pix_g, pix_b;
  logic         pix_valid;
  logic         pix_ready;
  logic [127:0] win_r, win_g, win_b;
  logic         win_valid;
  logic         win_ready;
  logic         frame_done;

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int windowCount = 0;
  int frameCount = 0;

  logic [383:0] expQ[$];
  int           expCycQ[$];
  bit           lastQ[$];
  logic [383:0] monExp;

  bit inDrain = 1'b0;
  bit shown = 1'b0;
  bit fdPending = 1'b0;
  bit stallArmed = 1'b0;
  bit stallActive = 1'b0;
  int stallLeft = 0;

  window_gen #(
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_r      (pix_r),
    .pix_g      (pix_g),
    .pix_b      (pix_b),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .win_r      (win_r),
    .win_g      (win_g),
    .win_b      (win_b),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .frame_done (frame_done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle index used for latency checks.
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [383:0] observed,
                             input logic [383:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic bit emits(int r, int c);
`ifdef WINDOW_GEN_STRIDE1_EN
    return (r >= 3) && (c >= 3);
`else
    return (r >= 3) && (c >= 3) && ((r - 3) % 2 == 0) && ((c - 3) % 2 == 0);
`endif
  endfunction

  // Expected {b,g,r} window with top-left (r0,c0) of the ramp image.
  function automatic logic [383:0] expWindow(int r0, int c0);
    logic [127:0] er, eg, eb;
    int v;
    er = '0;
    eg = '0;
    eb = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        v = (r0 + i) * W + (c0 + j);
        er[(4*i+j)*8 +: 8] = 8'(v);
        eg[(4*i+j)*8 +: 8] = 8'(v + 64);
        eb[(4*i+j)*8 +: 8] = 8'(v + 128);
      end
    end
    return {eb, eg, er};
  endfunction

  // Holds win_ready low for five cycles once the first window shows up.
  task automatic postEdge();
    if (stallArmed && !stallActive && win_valid) begin
      win_ready   = 1'b0;
      stallLeft   = 5;
      stallActive = 1'b1;
      stallArmed  = 1'b0;
    end else if (stallActive) begin
      stallLeft--;
      if (stallLeft == 0) begin
        win_ready   = 1'b1;
        stallActive = 1'b0;
      end
    end
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
    postEdge();
  endtask

  // Offers pixel (r,c) until accepted and records any window it triggers.
  task automatic applyStimulus(input int r, input int c, input bit toggle);
    bit acc;
    int waitCnt;
    pix_valid = 1'b1;
    pix_r = 8'(r * W + c);
    pix_g = 8'(r * W + c + 64);
    pix_b = 8'(r * W + c + 128);
    acc = 1'b0;
    waitCnt = 0;
    while (!acc && waitCnt < 100) begin
      @(negedge clk);
      acc = pix_ready;
      @(posedge clk);
      #1;
      postEdge();
      if (!acc) waitCnt++;
    end
    if (!acc) begin
      checkOutput("pixel_accept_timeout", 384'(acc), 384'(1));
    end else begin
      if (emits(r, c)) begin
        expQ.push_back(expWindow(r - 3, c - 3));
        expCycQ.push_back(cycle);
        lastQ.push_back((r == H - 1) && (c == W - 1));
      end
      if ((r == H - 1) && (c == W - 1)) inDrain = 1'b1;
    end
    pix_valid = 1'b0;
    if (toggle) idleCycle();
  endtask

  task automatic sendFrame(input int numPix, input bit toggle);
    for (int p = 0; p < numPix; p++) begin
      applyStimulus(p / W, p % W, toggle);
    end
  endtask

  task automatic waitFrames(input string tag, input int target);
    int n;
    n = 0;
    while (frameCount < target && n < 100) begin
      idleCycle();
      n++;
    end
    repeat (4) idleCycle();
    checkOutput(tag, 384'(frameCount), 384'(target));
  endtask

  // Monitor: reset values, ready logic, frame_done pulse, window data/latency.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("rst_win_valid", 384'(win_valid), 384'(0));
      checkOutput("rst_frame_done", 384'(frame_done), 384'(0));
      checkOutput("rst_win_r", 384'(win_r), 384'(0));
      checkOutput("rst_win_g", 384'(win_g), 384'(0));
      checkOutput("rst_win_b", 384'(win_b), 384'(0));
      checkOutput("rst_pix_ready", 384'(pix_ready), 384'(1));
      shown = 1'b0;
      fdPending = 1'b0;
    end else begin
      checkOutput("frame_done", 384'(frame_done), 384'(fdPending));
      fdPending = 1'b0;
      if (frame_done) frameCount++;
      checkOutput("pix_ready", 384'(pix_ready),
                  384'(!inDrain && (!win_valid || win_ready)));
      if (win_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("spurious_window", 384'(win_valid), 384'(0));
        end else begin
          monExp = expQ[0];
          checkOutput("win_r", 384'(win_r), 384'(monExp[127:0]));
          checkOutput("win_g", 384'(win_g), 384'(monExp[255:128]));
          checkOutput("win_b", 384'(win_b), 384'(monExp[383:256]));
          if (!shown) begin
            checkOutput("win_latency", 384'(cycle), 384'(expCycQ[0]));
            shown = 1'b1;
          end
          if (win_ready) begin
            if (lastQ[0]) begin
              inDrain = 1'b0;
              fdPending = 1'b1;
            end
            void'(expQ.pop_front());
            void'(expCycQ.pop_front());
            void'(lastQ.pop_front());
            windowCount++;
            shown = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    pix_valid = 1'b0;
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    win_ready = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;

    $display("[TB] basic frame, win_ready held high");
    windowCount = 0;
    sendFrame(W * H, 1'b0);
    waitFrames("frames_basic", 1);
    checkOutput("windows_basic", 384'(windowCount), 384'(EXPW));

    $display("[TB] frame with output stall after first window");
    windowCount = 0;
    stallArmed = 1'b1;
    sendFrame(W * H, 1'b0);
    waitFrames("frames_stall", 2);
    checkOutput("windows_stall", 384'(windowCount), 384'(EXPW));

    $display("[TB] frame with pix_valid toggling");
    windowCount = 0;
    sendFrame(W * H, 1'b1);
    waitFrames("frames_toggle", 3);
    checkOutput("windows_toggle", 384'(windowCount), 384'(EXPW));

    $display("[TB] reset mid-frame then fresh frame");
    windowCount = 0;
    sendFrame(20, 1'b0);
    rst = 1'b0;
    expQ.delete();
    expCycQ.delete();
    lastQ.delete();
    inDrain = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    sendFrame(W * H, 1'b0);
    waitFrames("frames_reset", 4);
    checkOutput("windows_reset", 384'(windowCount), 384'(EXPW));

    $display("[TB] two back-to-back frames");
    windowCount = 0;
    sendFrame(W * H, 1'b0);
    sendFrame(W * H, 1'b0);
    waitFrames("frames_b2b", 6);
    checkOutput("windows_b2b", 384'(windowCount), 384'(2 * EXPW));

    checkOutput("scoreboard_empty", 384'(expQ.size()), 384'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
